// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit MEM-stage word accesses into two timed 16-bit async SRAM accesses
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN     word read / write request (write wins if both)
//   address, write_data    byte address and store data from the MEM stage
//   read_data              loaded word, held until the next read completes
//   ready                  0 while an access is in flight (pipeline freeze)
//   sram_addr              half-word address on the external SRAM
//   sram_we_n              active-low write strobe
//   sram_dq_out/_oe/_in    split bidirectional data bus
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [SRAM_ADDR_W-2:0] r_word;
    logic [31:0]            r_wdata;
    logic                   r_wr;
    logic [31:0]            w_off;
    logic                   w_last;
    logic                   w_unused;
    assign w_off    = address - 32'(BASE_ADDR);
    // address bits outside the SRAM window are deliberately dropped (wrap)
    assign w_unused = ^{w_off[31:SRAM_ADDR_W+1], w_off[1:0]};
    assign w_last   = r_cnt == CW'(WAIT_CYCLES);
    assign ready    = r_state == DONE || !(MEM_R_EN || MEM_W_EN);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_wr        <= 1'b0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (MEM_R_EN || MEM_W_EN) begin
                    r_state     <= LOW;
                    r_cnt       <= '0;
                    r_word      <= w_off[SRAM_ADDR_W:2];
                    r_wdata     <= write_data;
                    r_wr        <= MEM_W_EN;
                    sram_addr   <= {w_off[SRAM_ADDR_W:2], 1'b0};
                    sram_dq_out <= write_data[15:0];
                    sram_we_n   <= !MEM_W_EN;
                    sram_dq_oe  <= MEM_W_EN;
                end
                LOW, HIGH: if (w_last) begin
                    r_cnt <= '0;
                    if (!r_wr && r_state == LOW) read_data[15:0] <= sram_dq_in;
                    if (!r_wr && r_state == HIGH) read_data[31:16] <= sram_dq_in;
                    r_state     <= r_state == LOW ? HIGH : DONE;
                    sram_addr   <= r_state == LOW ? {r_word, 1'b1} : sram_addr;
                    sram_dq_out <= r_state == LOW ? r_wdata[31:16] : sram_dq_out;
                    sram_we_n   <= r_state == LOW ? !r_wr : 1'b1;
                    sram_dq_oe  <= r_state == LOW ? r_wr : 1'b0;
                end else begin
                    r_cnt     <= r_cnt + 1'b1;
                    // strobe released on the final cycle of the phase for hold margin
                    sram_we_n <= !(r_wr && r_cnt < CW'(WAIT_CYCLES - 1));
                end
                DONE: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Data-memory back end for the 5-stage ARM pipeline. Sits directly downstream of the MEM stage and replaces its single-cycle memory array.
- Converts each 32-bit word read or write from the MEM stage into two 16-bit accesses on an external asynchronous SRAM.
- Holds `ready` low while the access is in flight. Top level ANDs `ready` into the freeze of every pipeline register.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: cycles per half-word phase minus one. Must be >= 1.
- SRAM_ADDR_W, 18: external SRAM address width, in 16-bit half-words.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- MEM_R_EN  in  1  word read request from MEM stage
- MEM_W_EN  in  1  word write request from MEM stage
- address  in  32  byte address (ALU result)
- write_data  in  32  store data (Val_Rm)
- read_data  out  32  loaded word
- ready  out  1  0 = pipeline must freeze
- sram_addr  out  SRAM_ADDR_W  half-word address
- sram_we_n  out  1  write strobe, active low
- sram_dq_out  out  16  data driven to SRAM
- sram_dq_oe  out  1  1 = controller drives the DQ bus
- sram_dq_in  in  16  data returned from SRAM

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, and has priority over everything.
- Reset values:
  - state = IDLE, wait counter = 0
  - read_data = 0, sram_addr = 0, sram_dq_out = 0
  - sram_we_n = 1, sram_dq_oe = 0
  - ready = 1 when no request is present
- Address mapping: word = (address - BASE_ADDR) >> 2, computed modulo 2^32. Then sram_addr = {word[SRAM_ADDR_W-2:0], half}, where half = 0 in LOW and 1 in HIGH. Upper bits are ignored, so out-of-range addresses wrap with no error.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If MEM_W_EN or MEM_R_EN is high, latch address, write_data and op, then go to LOW.
  - If both are high, op = write.
  - Otherwise stay in IDLE.
- LOW and HIGH:
  - Each phase lasts WAIT_CYCLES+1 cycles, counted by the wait counter. The counter clears on each phase entry.
  - sram_addr is stable for the whole phase.
  - Write phase: sram_dq_oe = 1 for the whole phase. sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH. sram_we_n = 0 for the first WAIT_CYCLES cycles and 1 in the last cycle (hold margin).
  - Read phase: sram_dq_oe = 0 and sram_we_n = 1. sram_dq_in is sampled on the last cycle of the phase into read_data[15:0] (LOW) or read_data[31:16] (HIGH).
  - LOW goes to HIGH, and HIGH goes to DONE, on the last cycle of the phase.
- DONE: lasts one cycle. Then go unconditionally to IDLE. DONE never accepts a new request.
- ready (combinational):
  - ready = 1 when the FSM is in DONE.
  - ready = 1 when MEM_R_EN and MEM_W_EN are both 0.
  - Otherwise ready = 0, including in IDLE when a request is present.
- Latency: at WAIT_CYCLES = 2 the sequence is IDLE(1) + LOW(3) + HIGH(3) + DONE(1), so ready rises in the 8th cycle after the request appears. In general, 2*(WAIT_CYCLES+1)+2 cycles.
- read_data after completion: holds its value until the next read completes. Writes do not change read_data.
- Back-to-back requests: the pipeline advances on the DONE edge. The next request is seen in IDLE on the following cycle. There is no lost or duplicated access.
- Request drop mid-transaction: inputs are latched, so the access still completes and the FSM returns to IDLE. ready = 1 for the whole time because no request is present.
- Reset mid-transaction: abort immediately to IDLE with reset values, so sram_we_n = 1 and sram_dq_oe = 0 next cycle. A partially written word is acceptable.

Test Plan:
1. Reset, with no requests for 5 cycles -> ready = 1, read_data = 0, sram_we_n = 1, sram_dq_oe = 0 throughout.
2. Write 0xDEADBEEF to address 1032 -> SRAM half-word 4 = 0xBEEF and half-word 5 = 0xDEAD. sram_we_n is low for exactly 2 cycles per phase. ready = 0 for 7 cycles, then 1 in cycle 8.
3. Read address 1032 with the SRAM model from scenario 2 -> read_data = 0xDEADBEEF in the DONE cycle, ready = 1 in cycle 8. sram_dq_oe stays 0 throughout.
4. Write 0x12345678 to address 1024, held across DONE, then a read of address 1024 -> the write takes 8 cycles, the read takes a further 8 cycles, and read_data = 0x12345678. There is no extra SRAM access between them.
5. MEM_R_EN and MEM_W_EN both high at address 1028 with data 0xCAFEF00D -> a write is performed: half-words 2 and 3 = 0xF00D and 0xCAFE. read_data is unchanged.
6. rst asserted during the 2nd cycle of HIGH of a write -> next cycle state = IDLE, sram_we_n = 1, sram_dq_oe = 0, read_data = 0. After rst drops with no request, ready = 1.
